mem_port_arbiter: RTL and testbench

- Shares one unified single-port memory between the instruction-fetch path and the load/store path of the RISC-V core.
- Sequences each access through issue/wait phases with a valid/grant handshake toward memory.
- Fixed data priority, with an anti-starvation limit for fetch and a response timeout.
- Sits between the core's fetch/LSU request logic and the shared memory model or controller.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store access to one shared single-port memory.
// One outstanding access, fixed data priority with a fetch anti-starvation limit.
module mem_port_arbiter #(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic [3:0]    d_we,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          m_req,
    output logic [AW-1:0] m_addr,
    output logic [3:0]    m_we,
    output logic [DW-1:0] m_wdata,
    input  logic          m_gnt,
    input  logic          m_rvalid,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int SW = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    state_t          state;
    logic            owner_d;
    logic [SW-1:0]   streak;
    logic [TW-1:0]   tmo_cnt;
    logic [AW-1:0]   addr_q;
    logic [3:0]      we_q;
    logic [DW-1:0]   wdata_q;

    logic            idle;
    logic            fetch_forced;
    logic            d_win;
    logic            f_win;
    logic            done;
    logic            tmo_hit;
    logic            rsp;
    logic            rsp_err;
    logic [DW-1:0]   rsp_data;

    // Grants are only offered from IDLE and never while reset is applied.
    assign idle         = (state == IDLE) && !reset;
    assign fetch_forced = if_req && (streak == STREAK_MAX);
    assign d_win        = idle && d_req && !fetch_forced;
    assign f_win        = idle && if_req && !d_win;

    assign if_gnt  = f_win;
    assign d_gnt   = d_win;
    assign m_req   = (state == ISSUE);
    assign m_addr  = addr_q;
    assign m_we    = we_q;
    assign m_wdata = wdata_q;
    assign busy    = (state != IDLE);

    // A same-cycle m_gnt/m_rvalid in ISSUE completes without a WAIT cycle.
    assign done = ((state == ISSUE) && m_gnt && m_rvalid) ||
                  ((state == WAIT) && m_rvalid);
    assign tmo_hit = (TIMEOUT != 0) && (state != IDLE) &&
                     (tmo_cnt == TMO_LAST);

    assign rsp      = done || tmo_hit;
    assign rsp_err  = !done;
    assign rsp_data = done ? m_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            streak    <= '0;
            tmo_cnt   <= '0;
            addr_q    <= '0;
            we_q      <= '0;
            wdata_q   <= '0;
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (d_win || f_win) begin
                        addr_q  <= d_win ? d_addr : if_addr;
                        we_q    <= d_win ? d_we : 4'b0000;
                        wdata_q <= d_wdata;
                        owner_d <= d_win;
                        tmo_cnt <= '0;
                        state   <= ISSUE;
                        if (f_win || !if_req) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + SW'(1);
                        end
                    end
                end
                ISSUE, WAIT: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (rsp) begin
                        state <= IDLE;
                        if (owner_d) begin
                            d_rvalid <= 1'b1;
                            d_err    <= rsp_err;
                            d_rdata  <= rsp_data;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_err    <= rsp_err;
                            if_rdata  <= rsp_data;
                        end
                    end else if ((state == ISSUE) && m_gnt) begin
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: linear steps plus a response scoreboard.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        m_req;
    logic [31:0] m_addr;
    logic [3:0]  m_we;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        busy;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_pass = 0;

    mem_port_arbiter #(
        .AW(32), .DW(32), .MAX_DATA_STREAK(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_d, input logic [31:0] data,
                        input logic err);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset && (if_rvalid || d_rvalid)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rvalid", {62'd0, if_rvalid, d_rvalid}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_port", {62'd0, if_rvalid, d_rvalid},
                    e.is_d ? 64'd1 : 64'd2);
                chk("sb_data", {32'd0, e.is_d ? d_rdata : if_rdata},
                    {32'd0, e.data});
                chk("sb_err", {63'd0, e.is_d ? d_err : if_err},
                    {63'd0, e.err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        if_req = 0; if_addr = 0;
        d_req = 0; d_addr = 0; d_we = 0; d_wdata = 0;
        m_gnt = 0; m_rvalid = 0; m_rdata = 0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_ctrl", {56'd0, busy, m_req, if_gnt, d_gnt,
                         if_rvalid, d_rvalid, if_err, d_err}, 64'd0);
        chk("rst_rdata", {if_rdata, d_rdata}, 64'd0);
        chk("rst_mbus", {m_addr, m_wdata}, 64'd0);
        tick();
        reset = 1'b0;

        // single fetch
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        chk("f_gnt", {62'd0, if_gnt, d_gnt}, 64'd2);
        chk("f_mreq_g", {63'd0, m_req}, 64'd0);
        push(1'b0, 32'h0013_0093, 1'b0);
        tick();
        if_req = 0; if_addr = 0; m_gnt = 1;
        @(negedge clk);
        chk("f_issue", {27'd0, m_req, m_we, m_addr}, {27'd0, 1'b1, 4'd0, 32'h10});
        tick();
        m_gnt = 0;
        @(negedge clk);
        chk("f_wait", {62'd0, m_req, busy}, 64'd1);
        tick();
        m_rvalid = 1; m_rdata = 32'h0013_0093;
        @(negedge clk);
        chk("f_rv_early", {63'd0, if_rvalid}, 64'd0);
        tick();
        m_rvalid = 0; m_rdata = 0;
        @(negedge clk);
        chk("f_rv", {31'd0, if_rvalid, if_rdata}, {31'd0, 1'b1, 32'h0013_0093});
        chk("f_d_quiet", {30'd0, d_rvalid, d_err, d_rdata}, 64'd0);
        tick();
        @(negedge clk);
        chk("f_hold", {31'd0, if_rvalid, if_rdata}, {31'd0, 1'b0, 32'h0013_0093});

        // store with 3 stall cycles
        tick();
        d_req = 1; d_addr = 32'h100; d_we = 4'b0011; d_wdata = 32'hBEEF_BEEF;
        @(negedge clk);
        chk("s_gnt", {62'd0, if_gnt, d_gnt}, 64'd1);
        push(1'b1, 32'h0, 1'b0);
        tick();
        d_req = 0; d_addr = 0; d_we = 0; d_wdata = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) m_gnt = 1;
            @(negedge clk);
            chk("s_issue", {27'd0, m_req, m_we, m_wdata},
                {27'd0, 1'b1, 4'b0011, 32'hBEEF_BEEF});
            chk("s_addr", {32'd0, m_addr}, 64'h100);
            tick();
        end
        m_gnt = 0; m_rvalid = 1;
        @(negedge clk);
        chk("s_rv_early", {63'd0, d_rvalid}, 64'd0);
        tick();
        m_rvalid = 0;
        @(negedge clk);
        chk("s_ack", {61'd0, d_rvalid, d_err, if_rvalid}, 64'd4);
        tick();

        // contention: D,D,D,D,F repeating
        if_req = 1; d_req = 1; if_addr = 32'h80; d_addr = 32'h180;
        for (int k = 0; k < 10; k++) begin
            logic exp_d;
            exp_d = (k % 5) != 4;
            @(negedge clk);
            chk($sformatf("cont_gnt_%0d", k), {62'd0, if_gnt, d_gnt},
                exp_d ? 64'd1 : 64'd2);
            push(exp_d, 32'hC000_0000 + k, 1'b0);
            tick();
            m_gnt = 1; m_rvalid = 1; m_rdata = 32'hC000_0000 + k;
            @(negedge clk);
            chk($sformatf("cont_addr_%0d", k), {32'd0, m_addr},
                exp_d ? 64'h180 : 64'h80);
            tick();
            m_gnt = 0; m_rvalid = 0; m_rdata = 0;
        end
        if_req = 0; d_req = 0;
        tick();

        // zero-latency completion
        d_req = 1; d_addr = 32'h200; d_we = 0;
        @(negedge clk);
        chk("zl_gnt", {63'd0, d_gnt}, 64'd1);
        push(1'b1, 32'hA5A5_A5A5, 1'b0);
        tick();
        d_req = 0; m_gnt = 1; m_rvalid = 1; m_rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("zl_mreq", {63'd0, m_req}, 64'd1);
        tick();
        m_gnt = 0; m_rvalid = 0; m_rdata = 0;
        @(negedge clk);
        chk("zl_done", {30'd0, busy, d_rvalid, d_rdata},
            {30'd0, 1'b0, 1'b1, 32'hA5A5_A5A5});
        tick();

        // timeout after 8 cycles in ISSUE/WAIT
        d_req = 1; d_addr = 32'h300;
        @(negedge clk);
        chk("to_gnt", {63'd0, d_gnt}, 64'd1);
        push(1'b1, 32'h0, 1'b1);
        tick();
        d_req = 0; m_gnt = 1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk($sformatf("to_wait_%0d", i), {62'd0, d_rvalid, busy}, 64'd1);
            tick();
            m_gnt = 0;
        end
        @(negedge clk);
        chk("to_rsp", {29'd0, d_rvalid, d_err, busy, d_rdata},
            {29'd0, 3'b110, 32'h0});
        chk("to_mreq", {63'd0, m_req}, 64'd0);
        tick();
        m_rvalid = 1; m_rdata = 32'hDEAD_0000;
        @(negedge clk);
        tick();
        m_rvalid = 0; m_rdata = 0;
        @(negedge clk);
        chk("to_stray", {61'd0, if_rvalid, d_rvalid, busy}, 64'd0);
        tick();
        if_req = 1; if_addr = 32'h40;
        @(negedge clk);
        chk("to_next_gnt", {62'd0, if_gnt, d_gnt}, 64'd2);
        push(1'b0, 32'h11, 1'b0);
        tick();
        if_req = 0; m_gnt = 1; m_rvalid = 1; m_rdata = 32'h11;
        tick();
        m_gnt = 0; m_rvalid = 0; m_rdata = 0;
        @(negedge clk);
        chk("to_next_rv", {31'd0, if_rvalid, if_rdata}, {31'd0, 1'b1, 32'h11});
        tick();

        // reset while in WAIT
        if_req = 1; d_req = 1; d_addr = 32'h400;
        @(negedge clk);
        chk("rw_gnt", {62'd0, if_gnt, d_gnt}, 64'd1);
        tick();
        if_req = 0; d_req = 0; m_gnt = 1;
        @(negedge clk);
        tick();
        m_gnt = 0;
        @(negedge clk);
        chk("rw_pre", {60'd0, busy, dut.streak}, {60'd0, 1'b1, 3'd1});
        tick();
        reset = 1;
        @(negedge clk);
        tick();
        reset = 0; m_rvalid = 1; m_rdata = 32'h77;
        @(negedge clk);
        chk("rw_ctrl", {56'd0, busy, m_req, if_gnt, d_gnt,
                        if_rvalid, d_rvalid, if_err, d_err}, 64'd0);
        chk("rw_rdata", {if_rdata, d_rdata}, 64'd0);
        chk("rw_streak", {61'd0, dut.streak}, 64'd0);
        tick();
        m_rvalid = 0; m_rdata = 0;
        @(negedge clk);
        chk("rw_stray", {62'd0, if_rvalid, d_rvalid}, 64'd0);
        repeat (3) tick();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
